// File: rtl/mux_ula_pkg.sv
// Shared types and helpers for the registered ALU operand multiplexer.
package mux_ula_pkg;

  localparam int unsigned CONTADOR_W = 16;

  typedef enum logic [1:0] {
    VAZIO,
    UM,
    DOIS
  } estado_t;

  function automatic logic sel_valido(input int unsigned flag, input int unsigned n);
    return flag < n;
  endfunction

endpackage

// File: rtl/mux_ula_skid.sv
// Two-slot valid/ready skid buffer: main slot drives the output, skid slot
// absorbs one extra word so ready_in can be a plain register.
module mux_ula_skid
  import mux_ula_pkg::*;
#(
  parameter int unsigned DADO_W = 33
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DADO_W-1:0] dado_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [DADO_W-1:0] dado_out,
  output logic              valid_out,
  input  logic              ready_out
);

  estado_t           estado_q, estado_d;
  logic [DADO_W-1:0] main_q, main_d;
  logic [DADO_W-1:0] skid_q, skid_d;
  logic              ready_in_q, ready_in_d;
  logic              valid_out_q, valid_out_d;
  logic              aceita;
  logic              transfere;

  // Occupancy transitions and slot loading.
  always_comb begin
    estado_d    = estado_q;
    main_d      = main_q;
    skid_d      = skid_q;
    aceita      = valid_in & ready_in_q;
    transfere   = valid_out_q & ready_out;
    case (estado_q)
      VAZIO: begin
        if (aceita) begin
          main_d   = dado_in;
          estado_d = UM;
        end
      end
      UM: begin
        if (aceita && !transfere) begin
          skid_d   = dado_in;
          estado_d = DOIS;
        end else if (aceita) begin
          main_d = dado_in;
        end else if (transfere) begin
          estado_d = VAZIO;
        end
      end
      DOIS: begin
        if (transfere) begin
          main_d   = skid_q;
          estado_d = UM;
        end
      end
      default: estado_d = VAZIO;
    endcase
    ready_in_d  = (estado_d != DOIS);
    valid_out_d = (estado_d != VAZIO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= VAZIO;
      main_q      <= '0;
      skid_q      <= '0;
      ready_in_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      ready_in_q  <= ready_in_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign ready_in  = ready_in_q;
  assign dado_out  = main_q;
  assign valid_out = valid_out_q;

endmodule

// File: rtl/multiplexador_ula_pipe.sv
// Registered N:1 ALU operand multiplexer with valid/ready output and
// out-of-range select detection. Optional MUX_ULA_CONTADOR_ERRO_EN adds a
// saturating count of accepted out-of-range selects.
module multiplexador_ula_pipe
  import mux_ula_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned N_ENTRADAS = 4,
  parameter int unsigned SEL_W      = $clog2(N_ENTRADAS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_ENTRADAS*WIDTH-1:0] entradas,
  input  logic [SEL_W-1:0]            flag,
  input  logic                        valid_in,
  output logic                        ready_in,
  output logic [WIDTH-1:0]            saida,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic                        erro_sel
`ifdef MUX_ULA_CONTADOR_ERRO_EN
  ,
  output logic [CONTADOR_W-1:0]       contador_erro
`endif
);

  localparam int unsigned DADO_W = WIDTH + 1;

  logic [WIDTH-1:0]  operando_c;
  logic              erro_c;
  logic [DADO_W-1:0] dado_saida;

  // Out-of-range selects fall back to entrada 0 and raise the error bit.
  always_comb begin
    operando_c = entradas[WIDTH-1:0];
    erro_c     = !sel_valido(32'(flag), N_ENTRADAS);
    for (int unsigned k = 1; k < N_ENTRADAS; k++) begin
      if (flag == SEL_W'(k)) operando_c = entradas[k*WIDTH +: WIDTH];
    end
  end

  mux_ula_skid #(
    .DADO_W(DADO_W)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .dado_in  ({erro_c, operando_c}),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .dado_out (dado_saida),
    .valid_out(valid_out),
    .ready_out(ready_out)
  );

  assign saida    = dado_saida[WIDTH-1:0];
  assign erro_sel = dado_saida[WIDTH];

`ifdef MUX_ULA_CONTADOR_ERRO_EN
  logic [CONTADOR_W-1:0] contador_q, contador_d;

  always_comb begin
    contador_d = contador_q;
    if (valid_in && ready_in && erro_c && (contador_q != '1))
      contador_d = contador_q + CONTADOR_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) contador_q <= '0;
    else       contador_q <= contador_d;
  end

  assign contador_erro = contador_q;
`endif

endmodule

// File: tb/tb_multiplexador_ula_pipe.sv
// Scoreboard bench for multiplexador_ula_pipe (WIDTH=32, N_ENTRADAS=5).
module tb_multiplexador_ula_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned SW = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [N*W-1:0]   entradas;
  logic [SW-1:0]    flag;
  logic             valid_in;
  logic             ready_in;
  logic [W-1:0]     saida;
  logic             valid_out;
  logic             ready_out;
  logic             erro_sel;
`ifdef MUX_ULA_CONTADOR_ERRO_EN
  logic [15:0]      contador_erro;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_bad   = 0;
  logic [W:0] sb_q[$];

  multiplexador_ula_pipe #(
    .WIDTH     (W),
    .N_ENTRADAS(N)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .entradas (entradas),
    .flag     (flag),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .saida    (saida),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .erro_sel (erro_sel)
`ifdef MUX_ULA_CONTADOR_ERRO_EN
    ,
    .contador_erro(contador_erro)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    n_tests++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Reference: unpack operands, pick by index, out-of-range -> operand 0 with error.
  function automatic logic [W:0] modelo(input logic [N*W-1:0] ent, input logic [SW-1:0] f);
    logic [W-1:0] ops[N];
    for (int k = 0; k < int'(N); k++) ops[k] = ent[k*W +: W];
    if (int'(f) < int'(N)) return {1'b0, ops[int'(f)]};
    return {1'b1, ops[0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Input side: every accepted word pushes its expected result.
  always @(negedge clock) begin
    if (reset) begin
      n_bad = 0;
    end else if (valid_in && ready_in) begin
      sb_q.push_back(modelo(entradas, flag));
      if (int'(flag) >= int'(N) && n_bad < 65535) n_bad++;
    end
  end

  // Output side: pop and compare on every transfer; check stall stability.
  logic         stall_prev = 1'b0;
  logic [W-1:0] saida_prev;
  logic         erro_prev;
  always @(negedge clock) begin
    logic [W:0] exp_w;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(valid_out), 64'(1));
        check("stall_saida", 64'(saida), 64'(saida_prev));
        check("stall_erro", 64'(erro_sel), 64'(erro_prev));
      end
      if (valid_out && ready_out) begin
        if (sb_q.size() == 0) begin
          check("spurious_word", 64'(saida), 64'(0));
          n_tests++; n_fail++;
          $display("FAIL spurious_transfer: got word 0x%0h, expected no valid word", saida);
        end else begin
          exp_w = sb_q.pop_front();
          check("sb_saida", 64'(saida), 64'(exp_w[W-1:0]));
          check("sb_erro", 64'(erro_sel), 64'(exp_w[W]));
        end
      end
      stall_prev = valid_out && !ready_out;
      saida_prev = saida;
      erro_prev  = erro_sel;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   espera;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    entradas  = '0;
    flag      = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_saida", 64'(saida), 64'(0));
    check("rst_erro", 64'(erro_sel), 64'(0));
    check("rst_ready_in", 64'(ready_in), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("rel_ready_in", 64'(ready_in), 64'(1));
    check("rel_valid_out", 64'(valid_out), 64'(0));

    // Basic select, back-to-back with downstream always ready.
    ready_out = 1'b1;
    for (int k = 0; k < int'(N); k++) entradas[k*W +: W] = 32'h11 * (k + 1);
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      flag     = SW'(i);
      tick();
      check("sel_valid", 64'(valid_out), 64'(1));
      check("sel_saida", 64'(saida), 64'(32'h11 * (i + 1)));
      check("sel_erro", 64'(erro_sel), 64'(0));
      check("sel_ready_in", 64'(ready_in), 64'(1));
    end
    valid_in = 1'b0;
    tick();
    check("sel_idle", 64'(valid_out), 64'(0));

    // Backpressure: two words fill the buffer, third is held upstream.
    ready_out = 1'b0;
    flag      = '0;
    valid_in  = 1'b1;
    entradas[W-1:0] = 32'hA1;
    tick();
    check("bp_ready1", 64'(ready_in), 64'(1));
    check("bp_saida1", 64'(saida), 64'(32'hA1));
    entradas[W-1:0] = 32'hA2;
    tick();
    check("bp_ready2", 64'(ready_in), 64'(0));
    entradas[W-1:0] = 32'hA3;
    tick();
    check("bp_ready3", 64'(ready_in), 64'(0));
    check("bp_hold", 64'(saida), 64'(32'hA1));
    ready_out = 1'b1;
    tick();
    check("bp_out2", 64'(saida), 64'(32'hA2));
    check("bp_ready4", 64'(ready_in), 64'(1));
    tick();
    check("bp_out3", 64'(saida), 64'(32'hA3));
    valid_in = 1'b0;
    tick();
    check("bp_empty", 64'(valid_out), 64'(0));
    check("bp_sb_empty", 64'(sb_q.size()), 64'(0));

    // Select boundary: last valid index, then out-of-range ones.
    entradas[W-1:0]     = 32'hDEAD;
    entradas[4*W +: W]  = 32'h4444;
    valid_in = 1'b1;
    flag     = 3'd4;
    tick();
    check("oor4_saida", 64'(saida), 64'(32'h4444));
    check("oor4_erro", 64'(erro_sel), 64'(0));
    for (int f = 5; f < 8; f++) begin
      flag = SW'(f);
      tick();
      check("oor_saida", 64'(saida), 64'(32'hDEAD));
      check("oor_erro", 64'(erro_sel), 64'(1));
    end
    valid_in = 1'b0;
    tick();
`ifdef MUX_ULA_CONTADOR_ERRO_EN
    check("cnt_after_oor", 64'(contador_erro), 64'(3));
`endif

    // Reset while both slots are full: nothing stale may come out later.
    ready_out = 1'b0;
    valid_in  = 1'b1;
    flag      = 3'd1;
    tick();
    tick();
    check("mid_full", 64'(ready_in), 64'(0));
    #2;
    reset    = 1'b1;
    valid_in = 1'b0;
    sb_q.delete();
    #1;
    check("mid_valid_out", 64'(valid_out), 64'(0));
    check("mid_saida", 64'(saida), 64'(0));
    check("mid_ready_in", 64'(ready_in), 64'(0));
    tick();
    check("mid_ready_hold", 64'(ready_in), 64'(0));
    @(negedge clock);
    reset     = 1'b0;
    ready_out = 1'b1;
    tick();
    check("mid_rel_ready", 64'(ready_in), 64'(1));
    check("mid_rel_valid", 64'(valid_out), 64'(0));
    tick();
    check("mid_no_stale", 64'(valid_out), 64'(0));
`ifdef MUX_ULA_CONTADOR_ERRO_EN
    check("cnt_reset", 64'(contador_erro), 64'(0));
`endif

    // Random traffic; upstream holds an offer until it is taken.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      acc = valid_in && ready_in;
      tick();
      if (!valid_in || acc) begin
        valid_in = 1'($urandom_range(0, 1));
        for (int k = 0; k < int'(N); k++) entradas[k*W +: W] = $urandom();
        flag = SW'($urandom_range(0, 7));
      end
      ready_out = 1'($urandom_range(0, 1));
    end

    valid_in  = 1'b0;
    ready_out = 1'b1;
    espera    = 0;
    while ((sb_q.size() != 0 || valid_out) && espera < 20) begin
      tick();
      espera++;
    end
    check("drain_sb", 64'(sb_q.size()), 64'(0));
    check("drain_valid", 64'(valid_out), 64'(0));
`ifdef MUX_ULA_CONTADOR_ERRO_EN
    check("cnt_random", 64'(contador_erro), 64'(n_bad));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplexador_ula_pipe.md
Name: multiplexador_ula_pipe

Overview:
Parametrised, registered successor to the 4:1 ALU operand multiplexer. It selects one of N_ENTRADAS WIDTH-bit operands with a binary flag and registers the result. The result is handed downstream through a valid/ready handshake. A 2-entry skid buffer gives full throughput under backpressure, and out-of-range selects are detected. Sits between the register-file/forwarding sources and the ALU operand input.

Parameters:
WIDTH, 32, operand width in bits
N_ENTRADAS, 4, number of selectable inputs (2..16)
SEL_W, $clog2(N_ENTRADAS), width of flag

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
entradas  input  N_ENTRADAS*WIDTH  packed operands; entrada k occupies bits [k*WIDTH +: WIDTH]
flag  input  SEL_W  binary select
valid_in  input  1  upstream offers entradas/flag this cycle
ready_in  output  1  block can accept this cycle
saida  output  WIDTH  selected operand (registered)
valid_out  output  1  saida valid
ready_out  input  1  downstream accepts saida
erro_sel  output  1  current saida was produced from an out-of-range flag

Behaviour:
- Reset (async, active-high):
  - valid_out=0, saida=0, erro_sel=0, ready_in=0 while reset is asserted; ready_in=1 from the first edge after release.
  - Both buffer slots are emptied; an in-flight word is discarded.
- Accept: valid_in & ready_in at a rising edge. Mux result = entradas[flag] if flag < N_ENTRADAS, else entrada 0 with erro bit set. erro bit is always 0 when N_ENTRADAS is a power of 2.
- Latency: 1 cycle. A word accepted at edge t is on saida/valid_out after edge t when the output slot is free.
- Transfer: valid_out & ready_out at an edge.
- Storage: main slot drives saida; skid slot holds one word. ready_in is a register equal to (skid slot empty), so it is not combinationally dependent on ready_out.
- States (occupancy):
  - VAZIO: accept -> UM.
  - UM: accept & !transfer -> DOIS (new word into skid). accept & transfer -> UM (new word into main). !accept & transfer -> VAZIO. Otherwise hold.
  - DOIS: ready_in=0. transfer -> UM, skid moves to main. Otherwise hold.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Stall: saida, erro_sel and valid_out are stable while valid_out & !ready_out.
- erro_sel travels with its word and is valid only when valid_out=1.
- valid_in with ready_in=0: ignored; upstream must hold its values.
- flag X/out-of-range when valid_in=0: no effect.

Optional Feature:
MUX_ULA_CONTADOR_ERRO_EN
- Defined: adds output port contador_erro [15:0]. It increments on every accepted word with an out-of-range flag and saturates at 16'hFFFF. Async reset to 0.
- Undefined: port and counter are absent; erro_sel behaviour is unchanged.

Decomposition:
- Package mux_ula_pkg:
  - estado_t enum {VAZIO, UM, DOIS}
  - function sel_valido(flag, n)
  - constant CONTADOR_W = 16
- Sub-module mux_ula_skid: generic 2-slot valid/ready skid buffer, parameter DADO_W = WIDTH+1 (data + erro bit). The top level holds only the combinational select and the optional counter.

Test Plan:
- Reset mid-stream: WIDTH=32, N=4; accept 2 words with ready_out=0 (state DOIS), pulse reset -> valid_out=0, saida=0, ready_in=0 while reset is high, ready_in=1 on the first edge after release; no stale word ever appears.
- Basic select: entradas={D,C,B,A}={0x44,0x33,0x22,0x11}, flag=0..3 back-to-back, ready_out=1 -> saida 0x11,0x22,0x33,0x44 on consecutive cycles, 1-cycle latency, erro_sel=0.
- Backpressure: ready_out=0 for 3 cycles while valid_in=1 streams 0xA1,0xA2,0xA3 -> ready_in drops after 2 accepts; saida holds 0xA1. On ready_out=1 the outputs are 0xA1,0xA2,0xA3 in order with no loss.
- Simultaneous accept+transfer in UM: streaming with ready_out=1 -> one word per cycle sustained, ready_in stays 1.
- Out-of-range: N=5, SEL_W=3, flag=6, entrada0=0xDEAD -> saida=0xDEAD, erro_sel=1. With MUX_ULA_CONTADOR_ERRO_EN defined, contador_erro=1. Preload the counter path to 0xFFFF and send one more bad flag -> stays 0xFFFF.
- Random: a scoreboard compares saida against a reference model of FIFO order, with random valid_in/ready_out at 50%, for 10k cycles.
